// File: rtl/comparator_ges_if.sv
// Operand/result bundle for the GES magnitude comparator.
// The master drives operands; the slave (the comparator) returns the registered result.
interface comparator_ges_if #(
    parameter int WIDTH = 32
);
  logic             valid_i;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sign;
  logic             valid_o;
  logic [2:0]       GES;

  modport master (
    output valid_i, A, B, sign,
    input  valid_o, GES
  );

  modport slave (
    input  valid_i, A, B, sign,
    output valid_o, GES
  );
endinterface

// File: rtl/comparator_ges.sv
// Registered one-hot (Greater/Equal/Smaller) magnitude comparator built from nibble slices and a merge tree.
// Define COMPARATOR_PIPE_EN to register the slice level as well (latency 2 instead of 1).
module comparator_ges #(
    parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  comparator_ges_if.slave   bus
);
  localparam int NS     = WIDTH / 4;
  localparam int LEVELS = $clog2(NS);
  localparam int NP     = 1 << LEVELS;

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;
  assign a_m = {bus.A[WIDTH-1] ^ bus.sign, bus.A[WIDTH-2:0]};
  assign b_m = {bus.B[WIDTH-1] ^ bus.sign, bus.B[WIDTH-2:0]};

  logic [NS-1:0] slice_gt_next;
  logic [NS-1:0] slice_eq_next;
  logic [NS-1:0] leaf_gt;
  logic [NS-1:0] leaf_eq;
  logic          leaf_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_slice
      assign slice_gt_next[gi] = a_m[gi*4 +: 4] > b_m[gi*4 +: 4];
      assign slice_eq_next[gi] = a_m[gi*4 +: 4] == b_m[gi*4 +: 4];
    end
  endgenerate

`ifdef COMPARATOR_PIPE_EN
  logic [NS-1:0] slice_gt_reg;
  logic [NS-1:0] slice_eq_reg;
  logic          valid_s1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      slice_gt_reg <= '0;
      slice_eq_reg <= '0;
      valid_s1_reg <= 1'b0;
    end else begin
      slice_gt_reg <= slice_gt_next;
      slice_eq_reg <= slice_eq_next;
      valid_s1_reg <= bus.valid_i;
    end
  end

  assign leaf_gt    = slice_gt_reg;
  assign leaf_eq    = slice_eq_reg;
  assign leaf_valid = valid_s1_reg;
`else
  assign leaf_gt    = slice_gt_next;
  assign leaf_eq    = slice_eq_next;
  assign leaf_valid = bus.valid_i;
`endif

  // Heap-ordered tree: node i has low child 2i+1 and high child 2i+2; leaves start at NP-1.
  logic [2*NP-2:0] node_gt;
  logic [2*NP-2:0] node_eq;

  generate
    for (gi = 0; gi < NP; gi++) begin : g_leaf
      if (gi < NS) begin : g_real
        assign node_gt[NP-1+gi] = leaf_gt[gi];
        assign node_eq[NP-1+gi] = leaf_eq[gi];
      end else begin : g_pad
        assign node_gt[NP-1+gi] = 1'b0;
        assign node_eq[NP-1+gi] = 1'b1;
      end
    end
    for (gi = 0; gi < NP - 1; gi++) begin : g_merge
      assign node_gt[gi] = node_gt[2*gi+2] | (node_eq[2*gi+2] & node_gt[2*gi+1]);
      assign node_eq[gi] = node_eq[2*gi+2] & node_eq[2*gi+1];
    end
  endgenerate

  logic [2:0] ges_next;
  logic [2:0] ges_reg;
  logic       valid_reg;

  always_comb begin
    ges_next = 3'b001;
    if (node_gt[0]) begin
      ges_next = 3'b100;
    end else if (node_eq[0]) begin
      ges_next = 3'b010;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      ges_reg   <= 3'b000;
    end else begin
      valid_reg <= leaf_valid;
      if (leaf_valid) begin
        ges_reg <= ges_next;
      end
    end
  end

  assign bus.valid_o = valid_reg;
  assign bus.GES     = ges_reg;
endmodule

// File: tb/tb_comparator_ges.sv
// Directed and random checks of comparator_ges against hand-computed and behavioural expectations.
module tb_comparator_ges;
  localparam int WIDTH = 32;
`ifdef COMPARATOR_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NRAND = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  comparator_ges_if #(.WIDTH(WIDTH)) bus ();

  comparator_ges #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Present one operation at a falling edge and wait until its result is visible.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.sign = s;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.A = ~a;
    bus.B = b ^ 32'h5A5A_5A5A;
    bus.sign = ~s;
    repeat (LAT - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.valid_i = 1'b1;
    bus.A = 32'h0000_0005;
    bus.B = 32'h0000_0003;
    bus.sign = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_valid cycle %0d: got %b want 0", c, bus.valid_o);
      end
      vectors++;
      if (bus.GES !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_ges cycle %0d: got %b want 000", c, bus.GES);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.GES !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_release: got valid=%b ges=%b want valid=1 ges=100", bus.valid_o, bus.GES);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vs [8];
    logic [2:0]  ve [8];
    va = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 32'h8000_0000, 32'h0000_0010, 32'h0000_0010};
    vb = '{32'h0000_0001, 32'h1234_5679, 32'h0000_0000, 32'h0000_0001,
           32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ve = '{3'b100, 3'b001, 3'b010, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100};
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], vs[i]);
      vectors++;
      if (bus.valid_o !== 1'b1 || bus.GES !== ve[i]) begin
        miscompares++;
        $display("FAIL directed_%0d A=%h B=%h sign=%b: got valid=%b ges=%b want valid=1 ges=%b",
                 i, va[i], vb[i], vs[i], bus.valid_o, bus.GES, ve[i]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vs [4];
    logic [2:0]  ve [4];
    va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7000_0000, 32'hF000_0001};
    vb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h6FFF_FFFF, 32'hF000_0002};
    vs = '{1'b0, 1'b1, 1'b1, 1'b1};
    ve = '{3'b010, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i]);
      vectors++;
      if (bus.GES !== ve[i]) begin
        miscompares++;
        $display("FAIL boundary_%0d A=%h B=%h sign=%b: got %b want %b",
                 i, va[i], vb[i], vs[i], bus.GES, ve[i]);
      end
    end
  endtask

  task automatic test_hold();
    run_op(32'h0000_0002, 32'h0000_0009, 1'b0);
    @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.GES !== 3'b001) begin
      miscompares++;
      $display("FAIL hold: got valid=%b ges=%b want valid=0 ges=001", bus.valid_o, bus.GES);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vs [4];
    logic [2:0]  ve [4];
    va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    vb = '{32'h0000_0001, 32'h0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vs = '{1'b0, 1'b1, 1'b0, 1'b1};
    ve = '{3'b100, 3'b001, 3'b100, 3'b001};
    for (int t = 0; t < 4 + LAT; t++) begin
      @(negedge clk);
      if (t >= LAT) begin
        vectors++;
        if (bus.valid_o !== 1'b1 || bus.GES !== ve[t-LAT]) begin
          miscompares++;
          $display("FAIL b2b_%0d: got valid=%b ges=%b want valid=1 ges=%b",
                   t - LAT, bus.valid_o, bus.GES, ve[t-LAT]);
        end
      end
      if (t < 4) begin
        bus.valid_i = 1'b1;
        bus.A = va[t];
        bus.B = vb[t];
        bus.sign = vs[t];
      end else begin
        bus.valid_i = 1'b0;
      end
    end
    @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_tail: got valid=%b want 0", bus.valid_o);
    end
  endtask

  task automatic test_reset_in_flight();
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.A = 32'h0000_0001;
    bus.B = 32'h0000_0000;
    bus.sign = 1'b0;
    @(negedge clk);
    bus.valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.GES !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_flight: got valid=%b ges=%b want valid=0 ges=000", bus.valid_o, bus.GES);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.GES !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_flight_drain: got valid=%b ges=%b want valid=0 ges=000", bus.valid_o, bus.GES);
    end
  endtask

  task automatic test_random(input logic s);
    logic [2:0] exp_q [$];
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0] e;
    for (int t = 0; t < NRAND + LAT; t++) begin
      @(negedge clk);
      if (t >= LAT) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.valid_o !== 1'b1 || bus.GES !== e || !$onehot(bus.GES)) begin
          miscompares++;
          $display("FAIL random_s%0b_%0d: got valid=%b ges=%b want valid=1 ges=%b",
                   s, t - LAT, bus.valid_o, bus.GES, e);
        end
      end
      if (t < NRAND) begin
        a = $urandom();
        b = $urandom();
        case ($urandom_range(0, 3))
          0: b = a;
          1: b = a ^ (32'h1 << $urandom_range(0, 31));
          default: ;
        endcase
        if (s ? ($signed(a) > $signed(b)) : (a > b)) e = 3'b100;
        else if (a == b) e = 3'b010;
        else e = 3'b001;
        exp_q.push_back(e);
        bus.valid_i = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.sign = s;
      end else begin
        bus.valid_i = 1'b0;
      end
    end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.sign = 1'b0;
    test_reset();
    test_directed();
    test_boundary();
    test_hold();
    test_back_to_back();
    test_reset_in_flight();
    test_random(1'b0);
    test_random(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
